// File: rtl/jtag_multi_chain_if.sv
// rtl/jtag_multi_chain_if.sv - TAP-side and user-side signal bundle for jtag_multi_chain
interface jtag_multi_chain_if #(
    parameter int NUM_CHAINS = 2,
    parameter int DR_WIDTH   = 32
);
    logic                           JTDI;
    logic                           JSHIFT;
    logic                           JUPDATE;
    logic [NUM_CHAINS-1:0]          JCE;
    logic [NUM_CHAINS-1:0]          JRTI;
    logic [NUM_CHAINS-1:0]          JTD;
    logic [NUM_CHAINS*DR_WIDTH-1:0] cap_data;
    logic [NUM_CHAINS*DR_WIDTH-1:0] upd_data;
    logic [NUM_CHAINS-1:0]          upd_valid;
    logic [NUM_CHAINS-1:0]          upd_err;
    logic [NUM_CHAINS-1:0]          rti_pulse;

    // TAP primitive / user logic side
    modport master (
        output JTDI, JSHIFT, JUPDATE, JCE, JRTI, cap_data,
        input  JTD, upd_data, upd_valid, upd_err, rti_pulse
    );

    // Chain block side
    modport slave (
        input  JTDI, JSHIFT, JUPDATE, JCE, JRTI, cap_data,
        output JTD, upd_data, upd_valid, upd_err, rti_pulse
    );
endinterface

// File: rtl/jtag_multi_chain.sv
// rtl/jtag_multi_chain.sv - multiple user data-register chains behind one TAP; optional JTAG_MULTI_CHAIN_PARITY_EN
module jtag_multi_chain #(
    parameter int NUM_CHAINS = 2,
    parameter int DR_WIDTH   = 32
) (
    input  logic              JTCK,
    input  logic              JRST,
    jtag_multi_chain_if.slave bus
);
    localparam int CW = $clog2(DR_WIDTH + 1) + 1;
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DR_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURED = 2'd1,
        ST_SHIFTING = 2'd2
    } state_t;

    state_t                         r_state [NUM_CHAINS];
    logic [DR_WIDTH-1:0]            r_shift [NUM_CHAINS];
    logic [CW-1:0]                  r_cnt   [NUM_CHAINS];
    logic [NUM_CHAINS*DR_WIDTH-1:0] r_upd_data;
    logic [NUM_CHAINS-1:0]          r_upd_valid;
    logic [NUM_CHAINS-1:0]          r_upd_err;
    logic [NUM_CHAINS-1:0]          r_rti_q;
    logic [NUM_CHAINS-1:0]          r_rti_pulse;

    logic [NUM_CHAINS-1:0]          w_sel;
    logic [NUM_CHAINS-1:0]          w_accept;
    logic [NUM_CHAINS-1:0]          w_jtd;

    // Lowest-index enabled chain wins; isolate its bit with x & -x
    assign w_sel = bus.JCE & (~bus.JCE + NUM_CHAINS'(1));

    // Per-chain update acceptance and serial output taken straight from the shift registers
    always_comb begin
        w_accept = '0;
        w_jtd    = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            w_jtd[i] = r_shift[i][0];
`ifdef JTAG_MULTI_CHAIN_PARITY_EN
            w_accept[i] = (r_cnt[i] == CNT_FULL) && !(^r_shift[i]);
`else
            w_accept[i] = (r_cnt[i] == CNT_FULL);
`endif
        end
    end

    // Chain state machines: capture, shift, and update/reject on Update-DR
    always_ff @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            for (int i = 0; i < NUM_CHAINS; i++) begin
                r_state[i] <= ST_IDLE;
                r_shift[i] <= '0;
                r_cnt[i]   <= '0;
            end
            r_upd_data  <= '0;
            r_upd_valid <= '0;
            r_upd_err   <= '0;
        end else begin
            r_upd_valid <= '0;
            r_upd_err   <= '0;
            for (int i = 0; i < NUM_CHAINS; i++) begin
                if (bus.JUPDATE) begin
                    r_state[i] <= ST_IDLE;
                    if (r_state[i] == ST_SHIFTING) begin
                        if (w_accept[i]) begin
                            r_upd_data[i*DR_WIDTH +: DR_WIDTH] <= r_shift[i];
                            r_upd_valid[i] <= 1'b1;
                        end else begin
                            r_upd_err[i] <= 1'b1;
                        end
                    end
                end else if (w_sel[i]) begin
                    if (!bus.JSHIFT) begin
                        if (r_state[i] == ST_IDLE) begin
                            r_state[i] <= ST_CAPTURED;
                            r_shift[i] <= bus.cap_data[i*DR_WIDTH +: DR_WIDTH];
                            r_cnt[i]   <= '0;
                        end
                    end else if (r_state[i] != ST_IDLE) begin
                        r_state[i] <= ST_SHIFTING;
                        r_shift[i] <= {bus.JTDI, r_shift[i][DR_WIDTH-1:1]};
                        if (r_cnt[i] != CNT_MAX) begin
                            r_cnt[i] <= r_cnt[i] + CW'(1);
                        end
                    end
                end
            end
        end
    end

    // Run-Test-Idle rising-edge detector
    always_ff @(posedge JTCK or posedge JRST) begin
        if (JRST) begin
            r_rti_q     <= '0;
            r_rti_pulse <= '0;
        end else begin
            r_rti_q     <= bus.JRTI;
            r_rti_pulse <= bus.JRTI & ~r_rti_q;
        end
    end

    assign bus.JTD       = w_jtd;
    assign bus.upd_data  = r_upd_data;
    assign bus.upd_valid = r_upd_valid;
    assign bus.upd_err   = r_upd_err;
    assign bus.rti_pulse = r_rti_pulse;
endmodule

// File: tb/tb_jtag_multi_chain.sv
// tb/tb_jtag_multi_chain.sv - self-checking bench for jtag_multi_chain
module tb_jtag_multi_chain;
    localparam int NC = 2;
    localparam int DW = 32;

    logic JTCK;
    logic JRST;
    jtag_multi_chain_if #(.NUM_CHAINS(NC), .DR_WIDTH(DW)) bus ();

    jtag_multi_chain #(.NUM_CHAINS(NC), .DR_WIDTH(DW)) dut (
        .JTCK (JTCK),
        .JRST (JRST),
        .bus  (bus)
    );

    initial JTCK = 1'b0;
    always #5 JTCK = ~JTCK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: each chain is "armed" after a capture and counts how many bits went in
    logic [DW-1:0]    m_word   [NC];
    int               m_nshift [NC];
    bit               m_armed  [NC];
    logic [NC-1:0]    m_rti_prev;
    logic [NC*DW-1:0] exp_data;
    logic [NC-1:0]    exp_valid, exp_err, exp_rti, exp_jtd;

    function automatic bit parity_ok(input logic [DW-1:0] w);
`ifdef JTAG_MULTI_CHAIN_PARITY_EN
        return (^w) == 1'b0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic tick();
        int sel;
        @(posedge JTCK);
        if (JRST) begin
            for (int i = 0; i < NC; i++) begin
                m_word[i] = '0; m_nshift[i] = 0; m_armed[i] = 0;
            end
            m_rti_prev = '0; exp_data = '0; exp_valid = '0; exp_err = '0; exp_rti = '0;
        end else begin
            exp_valid = '0;
            exp_err   = '0;
            exp_rti   = bus.JRTI & ~m_rti_prev;
            m_rti_prev = bus.JRTI;
            sel = -1;
            for (int i = NC - 1; i >= 0; i--) if (bus.JCE[i]) sel = i;
            for (int i = 0; i < NC; i++) begin
                if (bus.JUPDATE) begin
                    if (m_armed[i] && m_nshift[i] > 0) begin
                        if (m_nshift[i] == DW && parity_ok(m_word[i])) begin
                            exp_data[i*DW +: DW] = m_word[i];
                            exp_valid[i] = 1'b1;
                        end else begin
                            exp_err[i] = 1'b1;
                        end
                    end
                    m_armed[i] = 0;
                end else if (i == sel) begin
                    if (!bus.JSHIFT) begin
                        if (!m_armed[i]) begin
                            m_armed[i]  = 1;
                            m_word[i]   = bus.cap_data[i*DW +: DW];
                            m_nshift[i] = 0;
                        end
                    end else if (m_armed[i]) begin
                        m_word[i]   = (m_word[i] >> 1) | (DW'(bus.JTDI) << (DW - 1));
                        m_nshift[i] = m_nshift[i] + 1;
                    end
                end
            end
        end
        for (int i = 0; i < NC; i++) exp_jtd[i] = m_word[i][0];
        #1;
    endtask

    task automatic idle_inputs();
        bus.JTDI = 1'b0; bus.JSHIFT = 1'b0; bus.JUPDATE = 1'b0; bus.JCE = '0;
    endtask

    task automatic capture(input logic [NC-1:0] ce);
        bus.JCE = ce; bus.JSHIFT = 1'b0; bus.JUPDATE = 1'b0;
        tick();
        bus.JCE = '0;
    endtask

    task automatic shift_bits(input logic [NC-1:0] ce, input logic [63:0] data, input int n);
        for (int k = 0; k < n; k++) begin
            bus.JCE = ce; bus.JSHIFT = 1'b1; bus.JUPDATE = 1'b0; bus.JTDI = data[k];
            tick();
        end
        bus.JSHIFT = 1'b0; bus.JCE = '0;
    endtask

    task automatic update();
        bus.JCE = '0; bus.JSHIFT = 1'b0; bus.JUPDATE = 1'b1;
        tick();
        bus.JUPDATE = 1'b0;
    endtask

    task automatic test_reset();
        JRST = 1'b1; idle_inputs(); bus.JRTI = '0; bus.cap_data = '0;
        tick(); tick();
        n_checks++; if (bus.upd_data !== '0) begin n_fail++; $display("FAIL reset_upd_data got %h exp 0", bus.upd_data); end
        n_checks++; if (bus.upd_valid !== 2'b00 || bus.upd_err !== 2'b00) begin n_fail++; $display("FAIL reset_pulses got v=%b e=%b exp 00", bus.upd_valid, bus.upd_err); end
        n_checks++; if (bus.rti_pulse !== 2'b00 || bus.JTD !== 2'b00) begin n_fail++; $display("FAIL reset_rti_jtd got r=%b t=%b exp 00", bus.rti_pulse, bus.JTD); end
        JRST = 1'b0;
        tick();
    endtask

    task automatic test_basic_update();
        bus.cap_data = {$urandom, $urandom};
        capture(2'b01);
        shift_bits(2'b01, 64'hA5A5_0F0F, 32);
        update();
        n_checks++; if (bus.upd_valid !== 2'b01 || bus.upd_err !== 2'b00) begin n_fail++; $display("FAIL basic_pulse got v=%b e=%b exp v=01 e=00", bus.upd_valid, bus.upd_err); end
        n_checks++; if (bus.upd_data[31:0] !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL basic_data got %h exp a5a50f0f", bus.upd_data[31:0]); end
        tick();
        n_checks++; if (bus.upd_valid !== 2'b00) begin n_fail++; $display("FAIL basic_one_cycle got %b exp 00", bus.upd_valid); end
    endtask

    task automatic test_capture_readback();
        logic [31:0] cw;
        logic [31:0] seen;
        cw = 32'h1234_5678;
        bus.cap_data[63:32] = cw;
        capture(2'b10);
        for (int k = 0; k < 32; k++) begin
            seen[k] = bus.JTD[1];
            shift_bits(2'b10, 64'd0, 1);
        end
        n_checks++; if (seen !== cw) begin n_fail++; $display("FAIL readback_jtd got %h exp %h", seen, cw); end
        update();
        n_checks++; if (bus.upd_valid !== 2'b10 || bus.upd_data[63:32] !== 32'h0) begin n_fail++; $display("FAIL readback_upd got v=%b d=%h exp v=10 d=0", bus.upd_valid, bus.upd_data[63:32]); end
        n_checks++; if (bus.upd_data[31:0] !== 32'hA5A5_0F0F) begin n_fail++; $display("FAIL readback_other got %h exp a5a50f0f", bus.upd_data[31:0]); end
        tick();
    endtask

    task automatic test_length_error();
        int lens [2];
        logic [NC*DW-1:0] prev;
        lens[0] = 31; lens[1] = 40;
        foreach (lens[j]) begin
            prev = bus.upd_data;
            bus.cap_data = {$urandom, $urandom};
            capture(2'b01);
            shift_bits(2'b01, {$urandom, $urandom}, lens[j]);
            update();
            n_checks++; if (bus.upd_err !== 2'b01 || bus.upd_valid !== 2'b00) begin n_fail++; $display("FAIL len%0d_pulse got v=%b e=%b exp v=00 e=01", lens[j], bus.upd_valid, bus.upd_err); end
            n_checks++; if (bus.upd_data !== prev) begin n_fail++; $display("FAIL len%0d_hold got %h exp %h", lens[j], bus.upd_data, prev); end
            tick();
            n_checks++; if (bus.upd_err !== 2'b00) begin n_fail++; $display("FAIL len%0d_one_cycle got %b exp 00", lens[j], bus.upd_err); end
        end
    endtask

    task automatic test_arbitration();
        logic [31:0] d0, d1;
        logic        jtd1;
        d0 = $urandom; d1 = $urandom;
        bus.cap_data = {$urandom, $urandom};
        capture(2'b10);
        shift_bits(2'b10, {32'd0, d1}, 10);
        jtd1 = bus.JTD[1];
        capture(2'b11);
        shift_bits(2'b11, {32'd0, d0}, 32);
        n_checks++; if (bus.JTD[1] !== jtd1 || bus.JTD[1] !== exp_jtd[1]) begin n_fail++; $display("FAIL arb_chain1_held got %b exp %b", bus.JTD[1], jtd1); end
        shift_bits(2'b10, {42'd0, d1[31:10]}, 22);
        update();
        n_checks++; if (bus.upd_valid !== 2'b11) begin n_fail++; $display("FAIL arb_valid got %b exp 11", bus.upd_valid); end
        n_checks++; if (bus.upd_data !== {d1, d0}) begin n_fail++; $display("FAIL arb_data got %h exp %h", bus.upd_data, {d1, d0}); end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        bus.cap_data = {$urandom, $urandom};
        capture(2'b01);
        shift_bits(2'b01, {$urandom, $urandom}, 16);
        JRST = 1'b1;
        #2;
        n_checks++; if (bus.upd_data !== '0 || bus.JTD !== 2'b00) begin n_fail++; $display("FAIL rstmid_async got d=%h t=%b exp 0", bus.upd_data, bus.JTD); end
        tick();
        JRST = 1'b0;
        tick();
        update();
        n_checks++; if (bus.upd_valid !== 2'b00 || bus.upd_err !== 2'b00) begin n_fail++; $display("FAIL rstmid_no_pulse got v=%b e=%b exp 00", bus.upd_valid, bus.upd_err); end
        tick();
        n_checks++; if (bus.upd_valid !== 2'b00 || bus.upd_err !== 2'b00 || bus.upd_data !== '0) begin n_fail++; $display("FAIL rstmid_quiet got v=%b e=%b d=%h exp 0", bus.upd_valid, bus.upd_err, bus.upd_data); end
    endtask

    task automatic test_rti();
        for (int c = 0; c < 40; c++) begin
            bus.JRTI = NC'($urandom_range(0, 3));
            tick();
            n_checks++; if (bus.rti_pulse !== exp_rti) begin n_fail++; $display("FAIL rti_c%0d got %b exp %b", c, bus.rti_pulse, exp_rti); end
        end
        bus.JRTI = '0;
        tick();
    endtask

    task automatic test_random();
        int n;
        logic [NC-1:0] ce;
        for (int t = 0; t < 8; t++) begin
            ce = NC'($urandom_range(1, 3));
            n  = ($urandom_range(0, 2) == 0) ? $urandom_range(20, 40) : DW;
            bus.cap_data = {$urandom, $urandom};
            for (int c = 0; c < n + 3; c++) begin
                bus.JRTI = NC'($urandom_range(0, 3));
                bus.JTDI = 1'($urandom);
                bus.JCE = (c < n + 1) ? ce : NC'(0);
                bus.JSHIFT = (c >= 1 && c < n + 1);
                bus.JUPDATE = (c == n + 1);
                tick();
                n_checks++;
                if (bus.upd_valid !== exp_valid || bus.upd_err !== exp_err || bus.upd_data !== exp_data ||
                    bus.JTD !== exp_jtd || bus.rti_pulse !== exp_rti) begin
                    n_fail++;
                    $display("FAIL rnd_t%0d_c%0d got v=%b e=%b t=%b r=%b d=%h exp v=%b e=%b t=%b r=%b d=%h", t, c,
                             bus.upd_valid, bus.upd_err, bus.JTD, bus.rti_pulse, bus.upd_data,
                             exp_valid, exp_err, exp_jtd, exp_rti, exp_data);
                end
            end
        end
        idle_inputs(); bus.JRTI = '0;
        tick();
    endtask

    task automatic test_parity();
        logic [31:0] prev;
        prev = bus.upd_data[31:0];
        capture(2'b01);
        shift_bits(2'b01, 64'h1, 32);
        update();
`ifdef JTAG_MULTI_CHAIN_PARITY_EN
        n_checks++; if (bus.upd_err !== 2'b01 || bus.upd_data[31:0] !== prev) begin n_fail++; $display("FAIL parity_odd got e=%b d=%h exp e=01 d=%h", bus.upd_err, bus.upd_data[31:0], prev); end
`else
        n_checks++; if (bus.upd_valid !== 2'b01 || bus.upd_data[31:0] !== 32'h1) begin n_fail++; $display("FAIL parity_off got v=%b d=%h exp v=01 d=1", bus.upd_valid, bus.upd_data[31:0]); end
`endif
        tick();
        capture(2'b01);
        shift_bits(2'b01, 64'h3, 32);
        update();
        n_checks++; if (bus.upd_valid !== 2'b01 || bus.upd_err !== 2'b00 || bus.upd_data[31:0] !== 32'h3) begin n_fail++; $display("FAIL parity_even got v=%b e=%b d=%h exp v=01 e=00 d=3", bus.upd_valid, bus.upd_err, bus.upd_data[31:0]); end
        tick();
    endtask

    initial begin
        JRST = 1'b1;
        idle_inputs();
        bus.JRTI = '0;
        bus.cap_data = '0;
        m_rti_prev = '0;
        test_reset();
        test_basic_update();
        test_capture_readback();
        test_length_error();
        test_arbitration();
        test_reset_mid_shift();
        test_rti();
        test_random();
        test_parity();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
